// File: rtl/p23_mul_unit_pkg.sv
// Shared definitions for the RV32M multiplier: op encodings and the
// per-op signedness / half-select decode.
package p23_mul_unit_pkg;

  localparam int MUL_OP_WIDTH = 2;

  // Internal op code; equals funct3[1:0] of the RV32M multiply group.
  typedef enum logic [MUL_OP_WIDTH-1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  // rs1 is treated as signed for every op except MULHU.
  function automatic logic op_rs1_signed(input mul_op_e op);
    return op != MUL_OP_MULHU;
  endfunction

  // rs2 is treated as signed only for MUL and MULH.
  function automatic logic op_rs2_signed(input mul_op_e op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

  // Only MUL returns the low half of the product.
  function automatic logic op_low_half(input mul_op_e op);
    return op == MUL_OP_MUL;
  endfunction

endpackage

// File: rtl/p23_mul_step.sv
// One shift-add step of the radix-2^BITS_PER_CYCLE multiplier.
// The partial product is added into the top XLEN bits of the accumulator,
// then the whole sum shifts right by BITS_PER_CYCLE. After N steps the
// first partial product has moved down to bit 0, so the accumulator holds
// the full unsigned product without needing a position input.
module p23_mul_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [2*XLEN-1:0]         acc_in,
  input  logic [XLEN-1:0]           mcand,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  output logic [2*XLEN-1:0]         acc_out
);

  localparam int ACC_W = 2 * XLEN;
  localparam int PP_W  = XLEN + BITS_PER_CYCLE;
  localparam int SUM_W = ACC_W + BITS_PER_CYCLE;

  logic [PP_W-1:0]  partial;
  logic [SUM_W-1:0] sum;

  // Partial product, add into the upper half, retire BITS_PER_CYCLE bits.
  // NOTE: always_comb uses blocking '=' so later lines see earlier results;
  // only clocked state is written with '<='.
  always_comb begin
    partial = PP_W'(mcand) * PP_W'(slice);
    sum     = {{BITS_PER_CYCLE{1'b0}}, acc_in} + {partial, {XLEN{1'b0}}};
    acc_out = ACC_W'(sum >> BITS_PER_CYCLE);
  end

endmodule

// File: rtl/p23_mul_unit.sv
// Sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready
// request handshake, flush, and a one-cycle response pulse.
// Flow: IDLE --accept--> CALC (N steps) --> FIX (sign + half select) --> IDLE.
module p23_mul_unit
  import p23_mul_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            resp_valid,
  output logic [XLEN-1:0] rd,
  output logic            req_illegal
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  mul_op_e           op_q, op_d;
  logic              sign_q, sign_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              resp_valid_q, resp_valid_d;

  mul_op_e           req_op;
  logic              rs1_neg, rs2_neg, accept;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic [ACC_W-1:0]  step_acc, product;

  p23_mul_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_in  (acc_q),
    .mcand   (mcand_q),
    .slice   (mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_out (step_acc)
  );

  // Request decode: operand magnitudes, result sign, and acceptance.
  // abs(-2^(XLEN-1)) wraps to 2^(XLEN-1), which is correct as an unsigned magnitude.
  always_comb begin
    req_op      = mul_op_e'(funct3[1:0]);
    rs1_neg     = op_rs1_signed(req_op) & rs1[XLEN-1];
    rs2_neg     = op_rs2_signed(req_op) & rs2[XLEN-1];
    rs1_mag     = rs1_neg ? (~rs1 + 1'b1) : rs1;
    rs2_mag     = rs2_neg ? (~rs2 + 1'b1) : rs2;
    req_ready   = (state_q == S_IDLE);
    req_illegal = req_valid & funct3[2];
    accept      = req_valid & req_ready & ~funct3[2] & ~flush;
  end

  // Next-state logic for the FSM and datapath registers.
  // NOTE: every variable gets its hold/default value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    op_d         = op_q;
    sign_d       = sign_q;
    rd_d         = rd_q;
    resp_valid_d = 1'b0;
    product      = sign_q ? (~acc_q + 1'b1) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = rs1_mag;
          mplier_d = rs2_mag;
          op_d     = req_op;
          sign_d   = rs1_neg ^ rs2_neg;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = step_acc;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        // Flush is sampled here first so it always wins over the response.
        if (!flush) begin
          rd_d         = op_low_half(op_q) ? product[XLEN-1:0] : product[ACC_W-1:XLEN];
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous reset returns the unit to IDLE with rd cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      op_q         <= MUL_OP_MUL;
      sign_q       <= 1'b0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      op_q         <= op_d;
      sign_q       <= sign_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign rd         = rd_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_p23_mul_unit.sv
// Directed bench for p23_mul_unit. Three instances (BITS_PER_CYCLE 2, 1, 4)
// share the request inputs; the BITS_PER_CYCLE=2 instance is the primary one.
module tb_p23_mul_unit;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        flush;

  logic        req_ready, resp_valid, req_illegal;
  logic [31:0] rd;
  logic        req_ready1, resp_valid1, req_illegal1;
  logic [31:0] rd1;
  logic        req_ready4, resp_valid4, req_illegal4;
  logic [31:0] rd4;

  int n_tests = 0;
  int n_fail  = 0;

  p23_mul_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .resp_valid(resp_valid), .rd(rd), .req_illegal(req_illegal)
  );

  p23_mul_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready1),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .resp_valid(resp_valid1), .rd(rd1), .req_illegal(req_illegal1)
  );

  p23_mul_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready4),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .resp_valid(resp_valid4), .rd(rd4), .req_illegal(req_illegal4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to all instances, then record each instance's latency
  // (edges after the accept edge) and rd at its response pulse.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int l2, l1, l4;
    logic [31:0] r2, r1, r4;
    l2 = 0; l1 = 0; l4 = 0;
    r2 = '0; r1 = '0; r4 = '0;
    req_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    tick();
    req_valid = 1'b0; funct3 = 3'b011; rs1 = ~a; rs2 = ~b;
    check({tag, " busy"}, {31'd0, req_ready}, 32'd0);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (resp_valid  && l2 == 0) begin l2 = k; r2 = rd;  end
      if (resp_valid1 && l1 == 0) begin l1 = k; r1 = rd1; end
      if (resp_valid4 && l4 == 0) begin l4 = k; r4 = rd4; end
      if (l2 != 0 && l1 != 0 && l4 != 0) break;
    end
    check({tag, " rd b2"}, r2, exp);
    check({tag, " lat b2"}, l2, 32'd17);
    check({tag, " rd b1"}, r1, exp);
    check({tag, " lat b1"}, l1, 32'd33);
    check({tag, " rd b4"}, r4, exp);
    check({tag, " lat b4"}, l4, 32'd9);
  endtask

  // Watch all instances for a window and count any response pulses.
  task automatic quiet_window(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (resp_valid || resp_valid1 || resp_valid4) pulses++;
    end
    check({tag, " no resp"}, pulses, 32'd0);
  endtask

  initial begin
    int lat;
    resetn = 1'b0; req_valid = 1'b0; funct3 = 3'b000;
    rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Reset state
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset rd", rd, 32'd0);
    check("reset req_illegal", {31'd0, req_illegal}, 32'd0);

    // Main function, all four ops
    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("MULHSU 2*2^31", 3'b010, 32'd2, 32'h8000_0000, 32'h0000_0001);

    // Division funct3 is flagged and never accepted
    req_valid = 1'b1; funct3 = 3'b100; rs1 = 32'd6; rs2 = 32'd3;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("div illegal", {31'd0, req_illegal}, 32'd1);
      check("div ready", {31'd0, req_ready}, 32'd1);
      check("div resp", {31'd0, resp_valid}, 32'd0);
    end
    req_valid = 1'b0; funct3 = 3'b000;
    #1;
    check("illegal drop", {31'd0, req_illegal}, 32'd0);
    quiet_window("div", 40);

    // Flush after 5 CALC cycles
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush calc ready", {31'd0, req_ready}, 32'd1);
    check("flush calc resp", {31'd0, resp_valid}, 32'd0);
    check("flush calc rd", rd, 32'd1);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("flush idle ready", {31'd0, req_ready}, 32'd1);
    quiet_window("flush", 40);
    check("flush rd held", rd, 32'd1);
    run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12);

    // Flush during FIX suppresses the pulse
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
    tick();
    req_valid = 1'b0;
    repeat (16) tick();
    check("in fix busy", {31'd0, req_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush fix resp", {31'd0, resp_valid}, 32'd0);
    check("flush fix ready", {31'd0, req_ready}, 32'd1);
    check("flush fix rd", rd, 32'd12);
    quiet_window("flush fix", 40);

    // Asynchronous reset mid-CALC
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd7;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    check("async rst rd", rd, 32'd0);
    check("async rst rd b1", rd1, 32'd0);
    check("async rst ready", {31'd0, req_ready}, 32'd1);
    check("async rst resp", {31'd0, resp_valid}, 32'd0);
    tick();
    resetn = 1'b1;
    quiet_window("after rst", 40);

    // Back-to-back issue on the primary instance
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd3;
    tick();
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (resp_valid) begin lat = k; break; end
    end
    check("b2b first lat", lat, 32'd17);
    check("b2b first rd", rd, 32'd6);
    check("b2b ready with resp", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; rs1 = 32'd5; rs2 = 32'd5;
    tick();
    req_valid = 1'b0;
    check("b2b second accepted", {31'd0, req_ready}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (resp_valid) begin lat = k; break; end
    end
    check("b2b second lat", lat, 32'd17);
    check("b2b second rd", rd, 32'd25);

    // Resynchronise instances, then extra vectors across all step widths
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    run_op("MUL -1*-1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("MULH -1*1", 3'b001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_op("MULHSU min*max", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("MULHU 2^16*2^16", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    run_op("MUL 2^16*2^16", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_op("MUL 0x1234*0x100", 3'b000, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
